// File: rtl/ram_responder.sv
// Word-addressed RAM slave with a fixed LAT-cycle busy phase, abort-on-change and an error state.
// Optional RAM_ADDR_CHECK_EN: misaligned or out-of-range requests go to ERROR instead of accessing storage.
module ram_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] memaddr,
  input  logic [31:0] memstore,
  input  logic        memREN,
  input  logic        memWEN,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = DEPTH;
  localparam logic [3:0]  LAT_W   = 4'(LAT);

  typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic [31:0] ramload_q;
  logic [31:0] mem_q [DEPTH];

  logic          both_req, one_req, bad_addr;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_wdata;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] w;
    w = {2'b00, a[31:2]};
    return AW'(w % DEPTH_W);
  endfunction

  assign both_req = memREN & memWEN;
  assign one_req  = memREN ^ memWEN;

`ifdef RAM_ADDR_CHECK_EN
  assign bad_addr = (memaddr[1:0] != 2'b00) || ({2'b00, memaddr[31:2]} >= DEPTH_W);
`else
  assign bad_addr = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_idx   = word_idx(addr_q);
    mem_wdata = data_q;
    case (state_q)
      IDLE: begin
        if (both_req || (one_req && bad_addr)) begin
          state_d = ERR;
        end else if (one_req) begin
          addr_d = memaddr;
          data_d = memstore;
          wr_d   = memWEN;
          cnt_d  = LAT_W;
          if (LAT == 0) begin
            // Zero latency: the access happens on this very edge from the live inputs.
            state_d   = ACC;
            mem_idx   = word_idx(memaddr);
            mem_wdata = memstore;
            mem_we    = memWEN;
            mem_re    = memREN;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (both_req) begin
          state_d = ERR;
        end else if (!one_req || (memWEN != wr_q) || (memaddr != addr_q)) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = ACC;
          mem_we  = wr_q;
          mem_re  = !wr_q;
        end
      end
      ACC: state_d = IDLE;
      ERR: begin
        if (!(both_req || (one_req && bad_addr))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
    end
  end

  // Storage is never cleared; reset only suppresses a write landing on the same edge.
  always_ff @(posedge CLK) begin
    if (nRST && mem_we) mem_q[mem_idx] <= mem_wdata;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ramload_q <= 32'd0;
    end else if (mem_re) begin
      ramload_q <= mem_q[mem_idx];
    end
  end

  assign ramload = ramload_q;

  always_comb begin
    ramstate = 2'd0;
    case (state_q)
      IDLE: ramstate = 2'd0;
      WAIT: ramstate = 2'd1;
      ACC:  ramstate = 2'd2;
      ERR:  ramstate = 2'd3;
      default: ramstate = 2'd0;
    endcase
  end

endmodule
